data_mem_responder: RTL and testbench

Memory-side responder for the load/store path. It accepts one request at a time from the load/store unit over a valid/ready handshake and owns a word-organised synchronous data RAM. Loads are returned aligned and sign- or zero-extended; sub-word stores use read-modify-write so only the target lane changes. Misaligned or illegal requests get an error response and never touch memory.

---
 rtl/mem_pkg.sv | 56 +++++
 rtl/data_ram.sv | 27 ++
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM state
// type, and the lane extract/merge helpers used for sub-word accesses.
package mem_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_MODIFY = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    // Align the addressed lane to bit 0 and sign/zero extend it.
    function automatic logic [XLEN-1:0] lane_extract(
        input logic [XLEN-1:0] word,
        input logic [2:0]      f3,
        input logic [1:0]      off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (f3)
            F3_B:    lane_extract = {{24{b[7]}}, b};
            F3_BU:   lane_extract = {24'b0, b};
            F3_H:    lane_extract = {{16{h[15]}}, h};
            F3_HU:   lane_extract = {16'b0, h};
            default: lane_extract = word;
        endcase
    endfunction

    // Replace only the addressed byte or half lane of the old word.
    function automatic logic [XLEN-1:0] lane_merge(
        input logic [XLEN-1:0] old_word,
        input logic [15:0]     wlo,
        input logic [2:0]      f3,
        input logic [1:0]      off
    );
        logic [XLEN-1:0] bmask;
        logic [XLEN-1:0] hmask;
        bmask = 32'h0000_00FF << {off, 3'b000};
        hmask = 32'h0000_FFFF << {off[1], 4'b0000};
        if (f3 == F3_B)
            lane_merge = (old_word & ~bmask) | ({24'b0, wlo[7:0]} << {off, 3'b000});
        else
            lane_merge = (old_word & ~hmask) | ({16'b0, wlo} << {off[1], 4'b0000});
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port, word-wide RAM with synchronous read (read-before-write).
module data_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store memory responder: one request at a time, aligned/extended loads,
// read-modify-write sub-word stores, error response for misaligned/illegal ops.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned MEMORY_SIZE   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    state_e                   state_q, state_d;
    logic                     we_q, we_d;
    logic [2:0]               f3_q, f3_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    old_q, old_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic                     valid_q, valid_d;

    logic                     ram_we;
    logic [MEMORY_SIZE-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]    ram_wdata;
    logic [DATA_WIDTH-1:0]    ram_rdata;

    logic                     accept;
    logic                     illegal;
    logic                     misaligned;
    logic                     unused_bits;

    assign req_ready   = (state_q == S_IDLE) && !rst;
    assign accept      = req_valid && req_ready;
    assign unused_bits = ^{addr_q[ADDRESS_WIDTH-1:MEMORY_SIZE+2], wdata_q[DATA_WIDTH-1:16]};

    // Request classification, only meaningful in the accept cycle.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = req_we;
            default:          illegal = 1'b1;
        endcase
        case (req_funct3)
            F3_H, F3_HU: misaligned = req_addr[0];
            F3_W:        misaligned = |req_addr[1:0];
            default:     misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        old_d     = old_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        valid_d   = valid_q;
        ram_we    = 1'b0;
        ram_addr  = addr_q[MEMORY_SIZE+1:2];
        ram_wdata = lane_merge(old_q, wdata_q[15:0], f3_q, addr_q[1:0]);
        case (state_q)
            S_IDLE: begin
                ram_addr  = req_addr[MEMORY_SIZE+1:2];
                ram_wdata = req_wdata;
                if (accept) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (illegal || misaligned) begin
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        ram_we  = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (we_q) begin
                    old_d   = ram_rdata;
                    state_d = S_MODIFY;
                end else begin
                    rdata_d = lane_extract(ram_rdata, f3_q, addr_q[1:0]);
                    valid_d = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_MODIFY: begin
                ram_we  = 1'b1;
                valid_d = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    data_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MEMORY_SIZE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic, checked
// against a word-array memory model with per-request latency expectations.
module tb_data_mem_responder;

    localparam int unsigned MS = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] mem_m [1 << MS];
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic        exp_busy = 1'b0;

    data_mem_responder #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .MEMORY_SIZE   (MS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference behaviour: decode, memory update, response data and latency.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] ed, output logic ee,
                         output int lat);
        int          idx;
        int          off;
        logic [31:0] word;
        logic [31:0] b;
        logic [31:0] h;
        logic        ill;
        logic        mis;
        idx  = int'(addr[MS+1:2]);
        off  = int'(addr[1:0]);
        word = mem_m[idx];
        ill  = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
        mis  = ((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && addr[1:0] != 2'b00);
        ed   = '0;
        ee   = 1'b0;
        lat  = 2;
        if (ill || mis) begin
            ee  = 1'b1;
            lat = 1;
        end else if (we) begin
            if (f3 == 2) begin
                mem_m[idx] = wd;
                lat = 1;
            end else if (f3 == 0) begin
                mem_m[idx] = (word & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
                lat = 3;
            end else begin
                mem_m[idx] = (word & ~(32'hFFFF << (16 * (off / 2))))
                           | ((wd & 32'hFFFF) << (16 * (off / 2)));
                lat = 3;
            end
        end else begin
            b = (word >> (8 * off)) & 32'hFF;
            h = (word >> (16 * (off / 2))) & 32'hFFFF;
            case (f3)
                3'd0:    ed = b[7]  ? (b | 32'hFFFF_FF00) : b;
                3'd4:    ed = b;
                3'd1:    ed = h[15] ? (h | 32'hFFFF_0000) : h;
                3'd5:    ed = h;
                default: ed = word;
            endcase
        end
    endtask

    // One full request/response transaction with latency and handshake checks.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, output logic [31:0] got);
        int          n;
        int          lat;
        logic [31:0] ed;
        logic        ee;
        got = '0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!req_ready) begin
            miscompares++;
            $display("FAIL accept_timeout: req_ready stayed %b expected 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        model(we, f3, addr, wd, ed, ee, lat);
        exp_rdata = ed;
        exp_err   = ee;
        @(posedge clk);
        exp_busy = 1'b1;
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        check32("latency", 32'(n), 32'(lat));
        got = rsp_rdata;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_busy  = 1'b0;
        check32("post_handshake_valid_ready", {30'b0, rsp_valid, req_ready}, 32'h1);
    endtask

    // Every cycle a response is visible it must match the model and block requests.
    always @(negedge clk) begin
        if (!rst && (rsp_valid || exp_busy)) begin
            vectors++;
            if (rsp_valid && (!exp_busy || rsp_rdata !== exp_rdata || rsp_err !== exp_err
                              || req_ready !== 1'b0)) begin
                miscompares++;
                $display("FAIL rsp: got valid=%b rdata=%h err=%b ready=%b expected valid=%b rdata=%h err=%b ready=0",
                         rsp_valid, rsp_rdata, rsp_err, req_ready, exp_busy, exp_rdata, exp_err);
            end else if (!rsp_valid && req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_ready: got req_ready=%b expected 0", req_ready);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        for (int i = 0; i < (1 << MS); i++) mem_m[i] = '0;

        repeat (2) @(negedge clk);
        check32("reset_outputs", {rsp_valid, rsp_err, req_ready, rsp_rdata[28:0]}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check32("idle_ready", {31'b0, req_ready}, 32'h1);

        for (int i = 0; i < 64; i++) xact(1'b1, 3'd2, 32'(i * 4), $urandom(), 0, got);

        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, got);  check32("sw_rdata", got, 32'h0);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, got);         check32("lw_deadbeef", got, 32'hDEADBEEF);

        xact(1'b1, 3'd0, 32'h11, 32'h000000A5, 0, got);  check32("sb_rdata", got, 32'h0);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, got);         check32("lw_after_sb", got, 32'hDEADA5EF);
        xact(1'b0, 3'd0, 32'h11, 32'h0, 0, got);         check32("lb", got, 32'hFFFFFFA5);
        xact(1'b0, 3'd4, 32'h11, 32'h0, 0, got);         check32("lbu", got, 32'h000000A5);

        xact(1'b1, 3'd1, 32'h12, 32'h00001234, 0, got);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, got);         check32("lw_after_sh", got, 32'h1234A5EF);
        xact(1'b0, 3'd1, 32'h12, 32'h0, 0, got);         check32("lh", got, 32'h00001234);
        xact(1'b0, 3'd5, 32'h10, 32'h0, 0, got);         check32("lhu", got, 32'h0000A5EF);

        xact(1'b0, 3'd2, 32'h13, 32'h0, 0, got);
        xact(1'b0, 3'd1, 32'h11, 32'h0, 0, got);
        xact(1'b1, 3'd1, 32'h03, 32'hFFFF, 0, got);
        xact(1'b0, 3'd3, 32'h10, 32'h0, 0, got);
        xact(1'b1, 3'd4, 32'h10, 32'hFF, 0, got);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, got);         check32("lw_after_errors", got, 32'h1234A5EF);
        xact(1'b0, 3'd2, 32'h00, 32'h0, 0, got);

        xact(1'b0, 3'd2, 32'h10, 32'h0, 5, got);         check32("lw_held", got, 32'h1234A5EF);

        // Reset while the sb sits in its read cycle; the word must survive.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h10;
        req_wdata  = 32'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check32("rst_mid_outputs", {29'b0, rsp_valid, rsp_err, req_ready}, 32'h0);
        check32("rst_mid_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, got);         check32("lw_after_rst", got, 32'h1234A5EF);
        xact(1'b0, 3'd2, 32'h10 + (32'd4 << MS), 32'h0, 0, got);
        check32("lw_alias", got, 32'h1234A5EF);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2)
              | 32'($urandom_range(0, 3));
            xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
                 int'($urandom_range(0, 3)), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
